slm_line_transmitter: RTL and testbench
=======================================

Name: slm_line_transmitter

Overview:
- Consumer side of the timing controller's line handshake.
- Accepts a line when `line_of_data_available` is asserted, then reads exactly one line of 32-bit words from the dc32 FIFO.
- Optionally inverts the words for DC balance, drives them onto the SLM pixel bus with a row address, and reports line and frame completion back to the timing controller.
- Sits between the dc32 FIFO read port and the SLM pad interface, in the `fpga_clk` domain.

Parameters:
- DATA_W, 32: FIFO word and SLM data bus width.
- WORDS_PER_LINE, 40: words per SLM row (1280 px at 1 bpp).
- LINES_PER_FRAME, 1024: rows per frame.
- ROW_W, 10: row address width; must satisfy 2**ROW_W >= LINES_PER_FRAME.

Ports:
- fpga_clk  in  1  system clock.
- reset_all  in  1  asynchronous active-high reset.
- reset_per_frame  in  1  synchronous frame restart.
- line_of_data_available  in  1  level; the FIFO holds at least one full line.
- invert  in  1  invert the line's data; sampled at line accept.
- fifo_rd_data  in  DATA_W  FIFO read data; valid 1 cycle after `fifo_rd_en`.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  FIFO read strobe.
- slm_data  out  DATA_W  pixel word.
- slm_data_en  out  1  `slm_data` valid this cycle.
- slm_row_addr  out  ROW_W  row being written.
- slm_line_start  out  1  one-cycle pulse coincident with the first `slm_data_en` of a line.
- line_done  out  1  one-cycle pulse once a line has fully left the bus.
- frame_done  out  1  one-cycle pulse coincident with `line_done` of the last row.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (`reset_all`, async): state IDLE. All outputs 0. Word counter 0, row counter 0, latched invert 0.
- State machine: IDLE, READ, DRAIN, DONE.
- IDLE:
  - If `line_of_data_available` = 1 and `reset_per_frame` = 0: latch `invert` into `inv_q`, clear the word counter, go to READ.
- READ:
  - `fifo_rd_en` = !`fifo_empty`. The word counter increments on each issued read.
  - When read number WORDS_PER_LINE is issued, go to DRAIN.
  - `fifo_empty` mid-line is an underflow: no read is issued, the state holds and the output gaps. Nothing is dropped or duplicated.
- Pipeline, fixed latency 2:
  - `fifo_rd_en` high in cycle k ⇒ `slm_data` = `fifo_rd_data` XOR {DATA_W{`inv_q`}}, with `slm_data_en` = 1, in cycle k+2.
  - Otherwise `slm_data_en` = 0 and `slm_data` holds its last value.
- DRAIN: wait until the last word has been presented (2 cycles), then go to DONE.
- DONE, single cycle:
  - `line_done` = 1.
  - If row = LINES_PER_FRAME-1: `frame_done` = 1 and row wraps to 0. Otherwise row increments.
  - Go to IDLE. The next line cannot be accepted in the same cycle (minimum 1 idle cycle between lines).
- `slm_row_addr` is stable for the whole line. It changes only on the DONE→IDLE edge.
- `slm_line_start` fires on the first word of the line only. A gap before the first word delays it.
- `reset_per_frame` (synchronous, any state):
  - Aborts the current line; no further reads.
  - Pipeline `slm_data_en` is cleared next cycle.
  - Row and word counters clear to 0, state returns to IDLE.
  - No `line_done` or `frame_done` is emitted.
  - It has priority over `line_of_data_available` in the same cycle.
- `invert` changes mid-line have no effect until the next accept.

Optional Feature:
- Macro: SLM_TX_UNDERFLOW_CNT_EN.
- Enabled: adds output `underflow_cnt` [15:0], which counts cycles in READ with `fifo_empty` = 1.
  - Saturates at 16'hFFFF.
  - Cleared by `reset_all` only; `reset_per_frame` does not clear it.
- Disabled: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package `slm_pkg`:
  - state enum {IDLE, READ, DRAIN, DONE};
  - default constants for DATA_W, WORDS_PER_LINE, LINES_PER_FRAME and ROW_W, shared with `timing_controller`.
- One natural sub-module, `slm_tx_pipe`: the 2-stage read-data/valid/invert pipeline, including the `slm_line_start` tag.
- Counters and the state machine stay in the top level.

Test Plan:
- Single line, FIFO preloaded with 0..39, `invert` = 0, pulse `line_of_data_available` → `slm_data_en` high for 40 consecutive cycles, data 0..39 in order, row 0, `slm_line_start` on word 0, `line_done` 1 cycle after word 39, row becomes 1.
- Invert: same line with `invert` = 1 at accept, toggled to 0 mid-line → all 40 words = ~n; next line uninverted.
- Underflow: hold `fifo_empty` = 1 for 5 cycles after word 10 → gap of 5 cycles in `slm_data_en`, words 11..39 intact, 40 total; with SLM_TX_UNDERFLOW_CNT_EN, `underflow_cnt` = 5.
- Frame wrap: run 1024 lines → `frame_done` coincident with `line_done` of row 1023, `slm_row_addr` returns to 0.
- Abort: assert `reset_per_frame` at word 20 of row 7 → no further reads, no `line_done`, `busy` = 0 next cycle, next accepted line uses row 0.
- Async reset mid-READ: assert `reset_all` asynchronously → all outputs 0 immediately, FSM in IDLE after release.

Source files
------------

// File: rtl/slm_pkg.sv
// Shared SLM line-transmitter types and default geometry, also used by timing_controller.
package slm_pkg;

   localparam int DATA_W          = 32;
   localparam int WORDS_PER_LINE  = 40;
   localparam int LINES_PER_FRAME = 1024;
   localparam int ROW_W           = 10;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/slm_tx_pipe.sv
// Two-stage read-data pipeline: FIFO read strobe -> registered FIFO data -> SLM bus,
// applying the per-line invert and carrying the line-start tag alongside valid.
module slm_tx_pipe #(
   parameter int DATA_W = 32
) (
   input  logic              fpga_clk,
   input  logic              reset_all,
   input  logic              flush,
   input  logic              rd_en,
   input  logic              first,
   input  logic              inv,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] slm_data,
   output logic              slm_data_en,
   output logic              slm_line_start
);

   logic s1_valid;
   logic s1_first;
   logic s1_inv;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge fpga_clk or posedge reset_all) begin
      if (reset_all) begin
         s1_valid       <= 1'b0;
         s1_first       <= 1'b0;
         s1_inv         <= 1'b0;
         slm_data       <= '0;
         slm_data_en    <= 1'b0;
         slm_line_start <= 1'b0;
      end else if (flush) begin
         s1_valid       <= 1'b0;
         s1_first       <= 1'b0;
         slm_data_en    <= 1'b0;
         slm_line_start <= 1'b0;
      end else begin
         s1_valid       <= rd_en;
         s1_first       <= rd_en & first;
         s1_inv         <= inv;
         slm_data_en    <= s1_valid;
         slm_line_start <= s1_valid & s1_first;
         // FIFO data is valid one cycle after the strobe; the bus holds its last word otherwise.
         if (s1_valid) begin
            slm_data <= rd_data ^ {DATA_W{s1_inv}};
         end
      end
   end

endmodule

// File: rtl/slm_line_transmitter.sv
// Line consumer between the dc32 FIFO and the SLM pads. Define SLM_TX_UNDERFLOW_CNT_EN
// to add the saturating underflow_cnt output (cycles spent in READ with the FIFO empty).
module slm_line_transmitter
   import slm_pkg::*;
#(
   parameter int DATA_W          = slm_pkg::DATA_W,
   parameter int WORDS_PER_LINE  = slm_pkg::WORDS_PER_LINE,
   parameter int LINES_PER_FRAME = slm_pkg::LINES_PER_FRAME,
   parameter int ROW_W           = slm_pkg::ROW_W
) (
   input  logic              fpga_clk,
   input  logic              reset_all,
   input  logic              reset_per_frame,
   input  logic              line_of_data_available,
   input  logic              invert,
   input  logic [DATA_W-1:0] fifo_rd_data,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] slm_data,
   output logic              slm_data_en,
   output logic [ROW_W-1:0]  slm_row_addr,
   output logic              slm_line_start,
   output logic              line_done,
   output logic              frame_done,
   output logic              busy
`ifdef SLM_TX_UNDERFLOW_CNT_EN
   ,
   output logic [15:0]       underflow_cnt
`endif
);

   localparam int WCNT_W = $clog2(WORDS_PER_LINE + 1);
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_LINE - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(LINES_PER_FRAME - 1);

   state_t            state;
   logic [WCNT_W-1:0] word_cnt;
   logic [ROW_W-1:0]  row;
   logic              inv_q;
   logic              drain_cnt;

   // A frame restart suppresses the read issued in the same cycle, so nothing is lost mid-flight.
   assign fifo_rd_en   = (state == READ) && !fifo_empty && !reset_per_frame;
   assign busy         = (state != IDLE);
   assign slm_row_addr = row;

   always_ff @(posedge fpga_clk or posedge reset_all) begin
      if (reset_all) begin
         state      <= IDLE;
         word_cnt   <= '0;
         row        <= '0;
         inv_q      <= 1'b0;
         drain_cnt  <= 1'b0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         line_done  <= 1'b0;
         frame_done <= 1'b0;
         if (reset_per_frame) begin
            state     <= IDLE;
            word_cnt  <= '0;
            row       <= '0;
            drain_cnt <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (line_of_data_available) begin
                     inv_q    <= invert;
                     word_cnt <= '0;
                     state    <= READ;
                  end
               end
               READ: begin
                  if (fifo_rd_en) begin
                     word_cnt <= word_cnt + 1'b1;
                     if (word_cnt == LAST_WORD) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                     end
                  end
               end
               // Two cycles here cover the pipeline latency of the last read.
               DRAIN: begin
                  if (drain_cnt) begin
                     line_done  <= 1'b1;
                     frame_done <= (row == LAST_ROW);
                     state      <= DONE;
                  end else begin
                     drain_cnt <= 1'b1;
                  end
               end
               DONE: begin
                  row   <= (row == LAST_ROW) ? '0 : row + 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   slm_tx_pipe #(
      .DATA_W(DATA_W)
   ) u_pipe (
      .fpga_clk       (fpga_clk),
      .reset_all      (reset_all),
      .flush          (reset_per_frame),
      .rd_en          (fifo_rd_en),
      .first          (word_cnt == '0),
      .inv            (inv_q),
      .rd_data        (fifo_rd_data),
      .slm_data       (slm_data),
      .slm_data_en    (slm_data_en),
      .slm_line_start (slm_line_start)
   );

`ifdef SLM_TX_UNDERFLOW_CNT_EN
   // Diagnostic counter survives frame restarts; only the global reset clears it.
   always_ff @(posedge fpga_clk or posedge reset_all) begin
      if (reset_all) begin
         underflow_cnt <= '0;
      end else if ((state == READ) && fifo_empty && (underflow_cnt != 16'hFFFF)) begin
         underflow_cnt <= underflow_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_slm_line_transmitter.sv
// Self-checking bench for slm_line_transmitter: FIFO model, line-level reference model, per-cycle compare.
module tb_slm_line_transmitter;
   import slm_pkg::*;

   logic              fpga_clk = 1'b0;
   logic              reset_all;
   logic              reset_per_frame;
   logic              line_of_data_available;
   logic              invert;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] slm_data;
   logic              slm_data_en;
   logic [ROW_W-1:0]  slm_row_addr;
   logic              slm_line_start;
   logic              line_done;
   logic              frame_done;
   logic              busy;
`ifdef SLM_TX_UNDERFLOW_CNT_EN
   logic [15:0]       underflow_cnt;
`endif

   slm_line_transmitter dut (
      .fpga_clk               (fpga_clk),
      .reset_all              (reset_all),
      .reset_per_frame        (reset_per_frame),
      .line_of_data_available (line_of_data_available),
      .invert                 (invert),
      .fifo_rd_data           (fifo_rd_data),
      .fifo_empty             (fifo_empty),
      .fifo_rd_en             (fifo_rd_en),
      .slm_data               (slm_data),
      .slm_data_en            (slm_data_en),
      .slm_row_addr           (slm_row_addr),
      .slm_line_start         (slm_line_start),
      .line_done              (line_done),
      .frame_done             (frame_done),
      .busy                   (busy)
`ifdef SLM_TX_UNDERFLOW_CNT_EN
      ,
      .underflow_cnt          (underflow_cnt)
`endif
   );

   always #5 fpga_clk = ~fpga_clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 30)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // FIFO seen by the DUT, and the model's own copy of the same word stream.
   logic [DATA_W-1:0] fq[$];
   logic [DATA_W-1:0] mq[$];
   bit                force_empty = 1'b0;

   always @(posedge fpga_clk) begin
      if (fifo_rd_en && fq.size() > 0) begin
         fifo_rd_data <= fq[0];
         void'(fq.pop_front());
      end
   end

   task automatic upd_empty();
      fifo_empty = force_empty || (fq.size() == 0);
   endtask

   task automatic tick();
      @(posedge fpga_clk);
      #1;
      upd_empty();
   endtask

   // Reference model: line phase (0 idle, 1 reading, 2 waiting for the tail), read count, row, two-deep word pipe.
   bit                chk_on = 1'b0;
   int                m_mode, m_reads, m_tail, m_row, m_uf;
   bit                m_inv;
   bit                p1_v, p1_f, p2_v, p2_f;
   logic [DATA_W-1:0] p1_d, out_data;

   task automatic model_reset();
      m_mode = 0; m_reads = 0; m_tail = 0; m_row = 0; m_uf = 0; m_inv = 1'b0;
      p1_v = 1'b0; p1_f = 1'b0; p2_v = 1'b0; p2_f = 1'b0; p1_d = '0; out_data = '0;
   endtask

   // Per-line observation statistics used by the literal expectations.
   logic [DATA_W-1:0] obs[$];
   int gaps, pend, ld_cnt, start_pos, cyc, last_word_cyc, done_cyc;
   int fd_total, fd_row;
   bit fd_with_ld;

   always @(negedge fpga_clk) begin
      bit                e_rd, e_done;
      logic [DATA_W-1:0] w;
      if (chk_on) begin
         cyc++;
         e_rd   = (m_mode == 1) && !fifo_empty && !reset_per_frame;
         e_done = (m_mode == 2) && (m_tail == 3);
         check("fifo_rd_en", fifo_rd_en, e_rd);
         check("slm_data_en", slm_data_en, p2_v);
         check("slm_data", slm_data, out_data);
         check("slm_line_start", slm_line_start, p2_v && p2_f);
         check("line_done", line_done, e_done);
         check("frame_done", frame_done, e_done && (m_row == LINES_PER_FRAME - 1));
         check("slm_row_addr", slm_row_addr, m_row);
         check("busy", busy, m_mode != 0);
`ifdef SLM_TX_UNDERFLOW_CNT_EN
         check("underflow_cnt", underflow_cnt, m_uf);
`endif
         if (slm_data_en) begin
            if (slm_line_start) start_pos = obs.size();
            if (obs.size() > 0) gaps += pend;
            pend = 0;
            obs.push_back(slm_data);
            last_word_cyc = cyc;
         end else if (obs.size() > 0) begin
            pend++;
         end
         if (line_done) begin ld_cnt++; done_cyc = cyc; end
         if (frame_done) begin fd_total++; fd_row = slm_row_addr; fd_with_ld = line_done; end

         if (m_mode == 1 && fifo_empty && m_uf < 65535) m_uf++;
         if (reset_per_frame) begin
            m_mode = 0; m_row = 0; m_reads = 0; p1_v = 1'b0; p2_v = 1'b0;
         end else begin
            if (p1_v) out_data = p1_d;
            p2_v = p1_v; p2_f = p1_f;
            p1_v = e_rd;
            if (e_rd) begin
               w = 'x;
               if (mq.size() > 0) w = mq.pop_front();
               p1_d = w ^ {DATA_W{m_inv}};
               p1_f = (m_reads == 0);
            end
            case (m_mode)
               0: if (line_of_data_available) begin m_mode = 1; m_reads = 0; m_inv = invert; end
               1: if (e_rd) begin
                     m_reads++;
                     if (m_reads == WORDS_PER_LINE) begin m_mode = 2; m_tail = 1; end
                  end
               default: if (m_tail == 3) begin
                     m_mode = 0;
                     m_row  = (m_row == LINES_PER_FRAME - 1) ? 0 : m_row + 1;
                  end else m_tail++;
            endcase
         end
      end
   end

   // Offers one line and runs it to completion (or to an abort at cycle abort_at after accept).
   task automatic run_line(input bit inv, input bit idx_data, input int gap_at, input int gap_len,
                           input int abort_at, input bit rnd_gap);
      logic [DATA_W-1:0] w;
      bit finished = 1'b0;
      obs.delete(); gaps = 0; pend = 0; ld_cnt = 0; start_pos = -1;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
         w = idx_data ? DATA_W'(i) : DATA_W'($urandom);
         fq.push_back(w);
         mq.push_back(w);
      end
      line_of_data_available = 1'b1;
      invert = inv;
      upd_empty();
      tick();
      line_of_data_available = 1'b0;
      for (int c = 1; c < 300 && !finished; c++) begin
         invert          = 1'($urandom_range(0, 1));
         force_empty     = (c >= gap_at && c < gap_at + gap_len) ||
                           (rnd_gap && $urandom_range(0, 15) == 0);
         reset_per_frame = (c == abort_at);
         upd_empty();
         tick();
         if (c == abort_at) finished = 1'b1;
         else if (ld_cnt > 0 && !busy) finished = 1'b1;
      end
      if (!finished) check("line_timeout", 0, 1);
      reset_per_frame = 1'b0;
      force_empty     = 1'b0;
      upd_empty();
   endtask

   initial begin
      bit ok;
      reset_all = 1'b1; reset_per_frame = 1'b0; line_of_data_available = 1'b0;
      invert = 1'b0; fifo_rd_data = '0; fifo_empty = 1'b1;
      cyc = 0; fd_total = 0; fd_row = -1; fd_with_ld = 1'b0;
      model_reset();
      #1;
      check("rst_fifo_rd_en", fifo_rd_en, 0);
      check("rst_slm_data", slm_data, 0);
      check("rst_slm_data_en", slm_data_en, 0);
      check("rst_row", slm_row_addr, 0);
      check("rst_line_done", line_done, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_busy", busy, 0);
      tick();
      reset_all = 1'b0;
      chk_on = 1'b1;
      tick();

      // Plain line of 0..39.
      run_line(1'b0, 1'b1, 1000, 0, -1, 1'b0);
      ok = (obs.size() == WORDS_PER_LINE);
      for (int i = 0; i < obs.size(); i++) if (obs[i] !== DATA_W'(i)) ok = 1'b0;
      check("line0_words", ok, 1);
      check("line0_count", obs.size(), 40);
      check("line0_start_pos", start_pos, 0);
      check("line0_done_latency", done_cyc - last_word_cyc, 1);
      check("line0_gaps", gaps, 0);
      check("line0_row_after", slm_row_addr, 1);

      // Inverted line; invert toggles randomly mid-line inside run_line.
      run_line(1'b1, 1'b1, 1000, 0, -1, 1'b0);
      ok = (obs.size() == WORDS_PER_LINE);
      for (int i = 0; i < obs.size(); i++) if (obs[i] !== ~DATA_W'(i)) ok = 1'b0;
      check("inv_words", ok, 1);
      run_line(1'b0, 1'b1, 1000, 0, -1, 1'b0);
      check("uninv_word5", obs[5], 5);

      // Underflow: empty for 5 cycles right after read of word 10.
      run_line(1'b0, 1'b1, 12, 5, -1, 1'b0);
      check("uf_gap", gaps, 5);
      check("uf_count", obs.size(), 40);
      check("uf_word11", obs[11], 11);
      check("uf_word39", obs[39], 39);
`ifdef SLM_TX_UNDERFLOW_CNT_EN
      check("uf_cnt", underflow_cnt, 5);
`endif

      // Random lines up to row 7, then abort at word 20.
      while (slm_row_addr != 7 && n_err < 100)
         run_line(1'($urandom_range(0, 1)), 1'b0, 1000, 0, -1, 1'b1);
      run_line(1'b0, 1'b1, 1000, 0, 21, 1'b0);
      check("abort_busy", busy, 0);
      check("abort_no_done", ld_cnt, 0);
      check("abort_row", slm_row_addr, 0);
      repeat (3) tick();
      check("abort_no_late_data", slm_data_en, 0);
      fq.delete(); mq.delete();
      upd_empty();

      // Full frame from row 0 with random data, invert and underflow gaps.
      fd_total = 0;
      for (int l = 0; l < LINES_PER_FRAME && n_err < 100; l++)
         run_line(1'($urandom_range(0, 1)), 1'b0, 1000, 0, -1, 1'b1);
      check("frame_done_count", fd_total, 1);
      check("frame_done_row", fd_row, LINES_PER_FRAME - 1);
      check("frame_done_with_line_done", fd_with_ld, 1);
      check("frame_row_wrap", slm_row_addr, 0);

      // Asynchronous reset in the middle of a READ.
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
         fq.push_back(DATA_W'($urandom));
         mq.push_back(fq[$]);
      end
      line_of_data_available = 1'b1;
      upd_empty();
      tick();
      line_of_data_available = 1'b0;
      repeat (10) tick();
      #2;
      chk_on = 1'b0;
      reset_all = 1'b1;
      #1;
      check("arst_fifo_rd_en", fifo_rd_en, 0);
      check("arst_slm_data_en", slm_data_en, 0);
      check("arst_slm_data", slm_data, 0);
      check("arst_busy", busy, 0);
      check("arst_row", slm_row_addr, 0);
      repeat (2) tick();
      fq.delete(); mq.delete();
      model_reset();
      reset_all = 1'b0;
      upd_empty();
      chk_on = 1'b1;
      tick();
      check("arst_idle_after", busy, 0);
      run_line(1'b0, 1'b1, 1000, 0, -1, 1'b0);
      check("arst_line_count", obs.size(), 40);
      check("arst_row_after", slm_row_addr, 1);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
